// File: rtl/vpp_message_adder.sv
// V'' = (V' + e'' + Encode(m)) mod Q over all N coefficients.
// Streams one coefficient per cycle through a two-stage add/reduce pipeline into the V'' RAM.
module vpp_message_adder #(
    parameter int unsigned N      = 512,
    parameter int unsigned Q      = 12289,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   done,
    output logic [$clog2(N)-1:0]   addr_v,
    input  logic [15:0]            do_v,
    output logic [$clog2(N)-1:0]   addr_e,
    input  logic [15:0]            do_e,
    output logic [$clog2(N)-5:0]   addr_m,
    input  logic [7:0]             do_m,
    output logic                   we_vpp,
    output logic [$clog2(N)-1:0]   addr_vpp,
    output logic [15:0]            dout_vpp
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned DW = $clog2(RD_LAT + 2);
    localparam logic [AW-1:0] K_LAST     = AW'(N - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT + 1);
    localparam logic [16:0]   HALF_Q     = 17'(Q / 2);
    localparam logic [16:0]   Q1         = 17'(Q);
    localparam logic [16:0]   Q2         = 17'(2 * Q);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] k;
    logic [DW-1:0] dcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            dcnt  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        k     <= '0;
                    end
                end
                RUN: begin
                    // k wraps to 0 after the last index, parking the read addresses at 0
                    k <= k + AW'(1);
                    if (k == K_LAST) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    if (dcnt == DRAIN_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign addr_v = k;
    assign addr_e = k;
    assign addr_m = k[AW-2:3];

    // Issue valid and index delayed to line up with the RAM read data
    logic [RD_LAT-1:0] dl_vld;
    logic [AW-1:0]     dl_idx [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_vld <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                dl_idx[i] <= '0;
            end
        end else begin
            dl_vld[0] <= (state == RUN);
            dl_idx[0] <= k;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_idx[i] <= dl_idx[i-1];
            end
        end
    end

    logic          msg_bit;
    logic [16:0]   sum_c;
    logic          s1_vld;
    logic [16:0]   s1_sum;
    logic [AW-1:0] s1_idx;
    logic [15:0]   red;

    assign msg_bit = do_m[dl_idx[RD_LAT-1][2:0]];
    assign sum_c   = {1'b0, do_v} + {1'b0, do_e} + (msg_bit ? HALF_Q : 17'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_sum <= '0;
            s1_idx <= '0;
        end else begin
            s1_vld <= dl_vld[RD_LAT-1];
            s1_sum <= sum_c;
            s1_idx <= dl_idx[RD_LAT-1];
        end
    end

    // Sum is below 3Q, so at most two subtractions of Q are needed
    always_comb begin
        red = '0;
        if (s1_sum >= Q2) begin
            red = 16'(s1_sum - Q2);
        end else if (s1_sum >= Q1) begin
            red = 16'(s1_sum - Q1);
        end else begin
            red = s1_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_vpp   <= 1'b0;
            addr_vpp <= '0;
            dout_vpp <= '0;
        end else begin
            we_vpp <= s1_vld;
            if (s1_vld) begin
                addr_vpp <= s1_idx;
                dout_vpp <= red;
            end
        end
    end

endmodule

// File: tb/tb_vpp_message_adder.sv
// Scoreboard bench for vpp_message_adder: RD_LAT=1 and RD_LAT=2 instances run side by side
// on shared source memories; a negedge monitor checks every write and done pulse.
module tb_vpp_message_adder;

    localparam int N = 512;
    localparam int Q = 12289;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic        done_1, we_1, done_2, we_2;
    logic [8:0]  av_1, ae_1, avpp_1, av_2, ae_2, avpp_2;
    logic [4:0]  am_1, am_2;
    logic [15:0] dv_1, de_1, dout_1, dv_2, de_2, dout_2;
    logic [7:0]  dm_1, dm_2;

    vpp_message_adder #(.N(512), .Q(12289), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .done(done_1),
        .addr_v(av_1), .do_v(dv_1), .addr_e(ae_1), .do_e(de_1),
        .addr_m(am_1), .do_m(dm_1),
        .we_vpp(we_1), .addr_vpp(avpp_1), .dout_vpp(dout_1)
    );

    vpp_message_adder #(.N(512), .Q(12289), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .start(start), .done(done_2),
        .addr_v(av_2), .do_v(dv_2), .addr_e(ae_2), .do_e(de_2),
        .addr_m(am_2), .do_m(dm_2),
        .we_vpp(we_2), .addr_vpp(avpp_2), .dout_vpp(dout_2)
    );

    logic [15:0] vmem [N];
    logic [15:0] emem [N];
    logic [7:0]  mmem [32];
    logic [15:0] vp, ep;
    logic [7:0]  mp;

    always @(posedge clk) begin
        dv_1 <= vmem[av_1];
        de_1 <= emem[ae_1];
        dm_1 <= mmem[am_1];
        vp   <= vmem[av_2];
        ep   <= emem[ae_2];
        mp   <= mmem[am_2];
        dv_2 <= vp;
        de_2 <= ep;
        dm_2 <= mp;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_done [2];
    int   done_tot [2] = '{0, 0};
    int   done_base [2];
    int   expv [N];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic mon(input int d, input logic we, input logic [8:0] a,
                       input logic [15:0] dat, input logic dn);
        exp_t e;
        bit   have;
        if (we === 1'b1) begin
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                chk($sformatf("lat%0d_unexpected_write_addr%0d", d + 1, a), 1, 0);
            end else begin
                chk($sformatf("lat%0d_addr_k%0d", d + 1, e.addr), int'(a), e.addr);
                chk($sformatf("lat%0d_data_k%0d", d + 1, e.addr), int'(dat), e.data);
                chk($sformatf("lat%0d_wcycle_k%0d", d + 1, e.addr), cyc, e.cyc);
            end
        end
        if (dn === 1'b1) begin
            chk($sformatf("lat%0d_done_cycle", d + 1), cyc, exp_done[d]);
            done_tot[d]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, we_1, avpp_1, dout_1, done_1);
        mon(1, we_2, avpp_2, dout_2, done_2);
    end

    function automatic int model(input int k);
        int         j;
        logic [7:0] byt;
        j   = k % (N / 2);
        byt = mmem[j / 8];
        return (int'(vmem[k]) + int'(emem[k]) + (byt[j % 8] ? 6144 : 0)) % Q;
    endfunction

    task automatic reset_chk(input string tag);
        chk({tag, "_done1"}, int'(done_1), 0);
        chk({tag, "_we1"}, int'(we_1), 0);
        chk({tag, "_avpp1"}, int'(avpp_1), 0);
        chk({tag, "_dout1"}, int'(dout_1), 0);
        chk({tag, "_addrv1"}, int'(av_1), 0);
        chk({tag, "_addre1"}, int'(ae_1), 0);
        chk({tag, "_addrm1"}, int'(am_1), 0);
        chk({tag, "_done2"}, int'(done_2), 0);
        chk({tag, "_we2"}, int'(we_2), 0);
        chk({tag, "_avpp2"}, int'(avpp_2), 0);
        chk({tag, "_dout2"}, int'(dout_2), 0);
        chk({tag, "_addrv2"}, int'(av_2), 0);
        chk({tag, "_addre2"}, int'(ae_2), 0);
        chk({tag, "_addrm2"}, int'(am_2), 0);
    endtask

    // Start sampled at cyc base+1; write k lands at base+1+k+lat+2, done one cycle after the last write
    task automatic start_pass();
        int   base;
        exp_t e;
        @(posedge clk); #1;
        base = cyc;
        for (int k = 0; k < N; k++) begin
            e.addr = k;
            e.data = expv[k];
            e.cyc  = base + 1 + k + 1 + 2;
            q0.push_back(e);
            e.cyc  = base + 1 + k + 2 + 2;
            q1.push_back(e);
        end
        exp_done[0]  = base + 1 + N + 1 + 2;
        exp_done[1]  = base + 1 + N + 2 + 2;
        done_base[0] = done_tot[0];
        done_base[1] = done_tot[1];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_pass(input string tag);
        int t;
        t = 0;
        while ((done_tot[0] == done_base[0] || done_tot[1] == done_base[1]) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_done_within_budget"}, (t < 3000) ? 1 : 0, 1);
        repeat (20) @(posedge clk);
        #1;
        chk({tag, "_lat1_done_count"}, done_tot[0] - done_base[0], 1);
        chk({tag, "_lat2_done_count"}, done_tot[1] - done_base[1], 1);
        chk({tag, "_lat1_writes_left"}, q0.size(), 0);
        chk({tag, "_lat2_writes_left"}, q1.size(), 0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            vmem[k] = 16'($urandom_range(0, Q - 1));
            emem[k] = 16'($urandom_range(0, Q - 1));
        end
        for (int b = 0; b < 32; b++) mmem[b] = 8'($urandom_range(0, 255));
        for (int k = 0; k < N; k++) expv[k] = model(k);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin vmem[k] = '0; emem[k] = '0; end
        for (int b = 0; b < 32; b++) mmem[b] = '0;
        exp_done = '{-1, -1};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_chk("reset");
        rst = 1'b0;

        // all zero inputs
        for (int k = 0; k < N; k++) expv[k] = 0;
        start_pass();
        wait_pass("zero");

        // every message bit set
        for (int b = 0; b < 32; b++) mmem[b] = 8'hFF;
        for (int k = 0; k < N; k++) expv[k] = 6144;
        start_pass();
        wait_pass("msg_ones");

        // reduction boundaries: above 2Q, exactly Q, exactly 2Q
        for (int k = 0; k < N; k++) begin
            case (k % 3)
                0: begin vmem[k] = 16'd12288; emem[k] = 16'd12288; expv[k] = 6142; end
                1: begin vmem[k] = 16'd6145;  emem[k] = 16'd0;     expv[k] = 0;    end
                default: begin vmem[k] = 16'd12288; emem[k] = 16'd6146; expv[k] = 0; end
            endcase
        end
        start_pass();
        wait_pass("reduce");

        // first and last message bits each cover two coefficients
        for (int k = 0; k < N; k++) begin vmem[k] = '0; emem[k] = '0; expv[k] = 0; end
        for (int b = 0; b < 32; b++) mmem[b] = '0;
        mmem[0]  = 8'h01;
        mmem[31] = 8'h80;
        expv[0] = 6144; expv[256] = 6144; expv[255] = 6144; expv[511] = 6144;
        start_pass();
        wait_pass("bit_map");

        // reset mid-pass, with start asserted alongside it
        fill_random();
        start_pass();
        repeat (100) begin @(posedge clk); #1; end
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        q0.delete();
        q1.delete();
        exp_done = '{-1, -1};
        reset_chk("abort");
        repeat (40) @(posedge clk);
        #1;
        chk("abort_lat1_no_done", done_tot[0] - done_base[0], 0);
        chk("abort_lat2_no_done", done_tot[1] - done_base[1], 0);

        fill_random();
        start_pass();
        wait_pass("after_abort");

        // start pulses mid-pass and on the done cycle are ignored
        fill_random();
        start_pass();
        repeat (50) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < exp_done[0]) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_pass("restart_ignored");

        fill_random();
        start_pass();
        wait_pass("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
